// File: rtl/spi_sprite_cmd_parser.sv
// spi_sprite_cmd_parser
// Turns the host MCU byte stream into sprite_queue writes. Each DRAW_SPRITE
// command carries a 6-byte record that is buffered and then replayed as a
// 6-cycle enqueue burst. CMD_FRAME reports how many sprites were queued since
// the previous frame. Protocol problems raise sticky error flags.
module spi_sprite_cmd_parser #(
    parameter int         SPRITE_BYTES = 6,
    parameter logic [7:0] CMD_NOP      = 8'h00,
    parameter logic [7:0] CMD_SPRITE   = 8'h01,
    parameter logic [7:0] CMD_FRAME    = 8'h02
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_byte,
    input  logic       i_cs_active,
    input  logic       i_queue_full,
    input  logic       i_err_clear,
    output logic       o_enqueue_en,
    output logic [7:0] o_enqueue_data,
    output logic       o_frame_done,
    output logic [7:0] o_frame_sprites,
    output logic       o_busy,
    output logic       o_err_unknown_cmd,
    output logic       o_err_truncated,
    output logic       o_err_overflow
);

    localparam int               IDX_W    = $clog2(SPRITE_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SPRITE_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_BURST,
        ST_DISCARD
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_k;
    logic [7:0]       r_buf [SPRITE_BYTES];
    logic             r_pend_valid;
    logic [7:0]       r_pend_byte;
    logic [7:0]       r_count;

    logic             w_op_valid;
    logic [7:0]       w_op;
    logic [IDX_W-1:0] w_k_next;
    logic [7:0]       w_first_byte;

    // A byte held back during a burst takes precedence as the next opcode;
    // strobe spacing guarantees it never collides with a fresh strobe.
    assign w_op_valid   = r_pend_valid | i_rx_valid;
    assign w_op         = r_pend_valid ? r_pend_byte : i_rx_byte;
    assign w_k_next     = r_k + 1'b1;
    // The first burst byte is the id; it is only still in flight on a 1-byte record.
    assign w_first_byte = (r_idx == '0) ? i_rx_byte : r_buf[0];

    // Command FSM with all outputs registered so the queue sees clean strobes.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state           <= ST_IDLE;
            r_idx             <= '0;
            r_k               <= '0;
            r_pend_valid      <= 1'b0;
            r_pend_byte       <= '0;
            r_count           <= '0;
            for (int i = 0; i < SPRITE_BYTES; i++) begin
                r_buf[i] <= '0;
            end
            o_enqueue_en      <= 1'b0;
            o_enqueue_data    <= '0;
            o_frame_done      <= 1'b0;
            o_frame_sprites   <= '0;
            o_busy            <= 1'b0;
            o_err_unknown_cmd <= 1'b0;
            o_err_truncated   <= 1'b0;
            o_err_overflow    <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;

            if (i_err_clear) begin
                o_err_unknown_cmd <= 1'b0;
                o_err_truncated   <= 1'b0;
                o_err_overflow    <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_op_valid) begin
                        r_pend_valid <= 1'b0;
                        if (w_op == CMD_SPRITE) begin
                            r_idx   <= '0;
                            r_state <= ST_COLLECT;
                            o_busy  <= 1'b1;
                        end else if (w_op == CMD_FRAME) begin
                            o_frame_done    <= 1'b1;
                            o_frame_sprites <= r_count;
                            r_count         <= '0;
                        end else if (w_op != CMD_NOP) begin
                            o_err_unknown_cmd <= 1'b1;
                            r_state           <= ST_DISCARD;
                            o_busy            <= 1'b1;
                        end
                    end
                end

                ST_COLLECT: begin
                    if (i_rx_valid) begin
                        r_buf[r_idx] <= i_rx_byte;
                        if (r_idx == LAST_IDX) begin
                            if (i_queue_full) begin
                                o_err_overflow <= 1'b1;
                                r_state        <= ST_IDLE;
                                o_busy         <= 1'b0;
                            end else begin
                                r_k            <= '0;
                                o_enqueue_en   <= 1'b1;
                                o_enqueue_data <= w_first_byte;
                                r_state        <= ST_BURST;
                            end
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else if (!i_cs_active) begin
                        o_err_truncated <= 1'b1;
                        r_state         <= ST_IDLE;
                        o_busy          <= 1'b0;
                    end
                end

                ST_BURST: begin
                    if (i_rx_valid) begin
                        r_pend_valid <= 1'b1;
                        r_pend_byte  <= i_rx_byte;
                    end
                    if (r_k == LAST_IDX) begin
                        o_enqueue_en   <= 1'b0;
                        o_enqueue_data <= '0;
                        r_state        <= ST_IDLE;
                        o_busy         <= 1'b0;
                        if (r_count != 8'hFF) begin
                            r_count <= r_count + 8'd1;
                        end
                    end else begin
                        r_k            <= w_k_next;
                        o_enqueue_data <= r_buf[w_k_next];
                    end
                end

                ST_DISCARD: begin
                    if (!i_cs_active) begin
                        r_state <= ST_IDLE;
                        o_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sprite_cmd_parser.sv
// tb_spi_sprite_cmd_parser
// Drives command streams byte by byte and compares the parser against a
// command-level model built from queues and counters.
module tb_spi_sprite_cmd_parser;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxValid;
    logic [7:0] rxByte;
    logic       csActive;
    logic       queueFull;
    logic       errClear;
    logic       enqEn;
    logic [7:0] enqData;
    logic       frameDone;
    logic [7:0] frameSprites;
    logic       busy;
    logic       errUnk;
    logic       errTrunc;
    logic       errOvf;

    int errors = 0;
    int checks = 0;

    // Observations after each strobe: index i is the cycle after edge N+i.
    logic       obsEn   [7];
    logic [7:0] obsData [7];
    logic       obsFd   [7];
    logic       obsBusy [7];

    // Monitor bookkeeping.
    logic [7:0] gotBytes [$];
    int         gotFrames   = 0;
    int         badIdleData = 0;
    int         badBurstLen = 0;
    int         runLen      = 0;

    // Reference model state.
    logic [7:0] mPayload [$];
    logic [7:0] expBytes [$];
    bit         mCollect;
    bit         mDiscard;
    int         mRun;
    logic [7:0] mFrameSprites;
    int         mFrames = 0;
    bit         mUnk;
    bit         mTrunc;
    bit         mOvf;

    spi_sprite_cmd_parser dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .i_rx_valid        (rxValid),
        .i_rx_byte         (rxByte),
        .i_cs_active       (csActive),
        .i_queue_full      (queueFull),
        .i_err_clear       (errClear),
        .o_enqueue_en      (enqEn),
        .o_enqueue_data    (enqData),
        .o_frame_done      (frameDone),
        .o_frame_sprites   (frameSprites),
        .o_busy            (busy),
        .o_err_unknown_cmd (errUnk),
        .o_err_truncated   (errTrunc),
        .o_err_overflow    (errOvf)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    // Collects every enqueued byte and polices burst length and idle data.
    always @(negedge clk) begin
        if (reset) begin
            runLen = 0;
        end else begin
            if (frameDone) gotFrames++;
            if (enqEn) begin
                gotBytes.push_back(enqData);
                runLen++;
            end else begin
                if (enqData !== 8'h00) badIdleData++;
                if (runLen != 0 && runLen != 6) badBurstLen++;
                runLen = 0;
            end
        end
    end

    // Hard stop in case something stalls.
    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "[TB] watchdog");
    end

    function automatic void modelReset();
        mPayload.delete();
        mCollect      = 0;
        mDiscard      = 0;
        mRun          = 0;
        mFrameSprites = 8'h00;
        mUnk          = 0;
        mTrunc        = 0;
        mOvf          = 0;
    endfunction

    function automatic void modelByte(logic [7:0] b, bit qfull, bit clr);
        if (clr) begin
            mUnk = 0; mTrunc = 0; mOvf = 0;
        end
        if (mDiscard) return;
        if (mCollect) begin
            mPayload.push_back(b);
            if (mPayload.size() == 6) begin
                mCollect = 0;
                if (qfull) mOvf = 1;
                else begin
                    foreach (mPayload[i]) expBytes.push_back(mPayload[i]);
                    if (mRun < 255) mRun++;
                end
            end
            return;
        end
        case (b)
            8'h00: ;
            8'h01: begin mCollect = 1; mPayload.delete(); end
            8'h02: begin mFrames++; mFrameSprites = 8'(mRun); mRun = 0; end
            default: begin mUnk = 1; mDiscard = 1; end
        endcase
    endfunction

    function automatic void modelCsRelease();
        if (mCollect) begin
            mTrunc   = 1;
            mCollect = 0;
        end
        mDiscard = 0;
    endfunction

    // One strobe, then seven quiet cycles so strobes stay 8 clocks apart.
    task automatic sendByte(input logic [7:0] b, input bit qfull, input bit clr);
        @(negedge clk);
        rxValid   = 1'b1;
        rxByte    = b;
        queueFull = qfull;
        errClear  = clr;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 0) begin
                rxValid   = 1'b0;
                errClear  = 1'b0;
                rxByte    = 8'($urandom);
                queueFull = 1'($urandom_range(0, 1));
            end
            obsEn[i]   = enqEn;
            obsData[i] = enqData;
            obsFd[i]   = frameDone;
            obsBusy[i] = busy;
        end
        modelByte(b, qfull, clr);
    endtask

    task automatic releaseCs();
        @(negedge clk);
        csActive = 1'b0;
        repeat (3) @(negedge clk);
        csActive = 1'b1;
        @(negedge clk);
        modelCsRelease();
    endtask

    task automatic pulseErrClear();
        @(negedge clk);
        errClear = 1'b1;
        @(negedge clk);
        errClear = 1'b0;
        mUnk = 0; mTrunc = 0; mOvf = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; rxValid = 1'b0; rxByte = 8'h00; csActive = 1'b1;
        queueFull = 1'b0; errClear = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        checks++;
        if ({enqEn, enqData, frameDone, frameSprites, busy, errUnk, errTrunc, errOvf} !== 22'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h required 0",
                     {enqEn, enqData, frameDone, frameSprites, busy, errUnk, errTrunc, errOvf});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_single_sprite();
        logic [7:0] seq [6] = '{8'h01, 8'h10, 8'h04, 8'h80, 8'h00, 8'h02};
        bit bad;
        gotBytes.delete(); expBytes.delete();
        sendByte(8'h01, 1'b0, 1'b0);
        checks++;
        if (obsBusy[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sprite_busy: got %b required 1", obsBusy[0]);
        end
        for (int i = 0; i < 5; i++) sendByte(seq[i], 1'b0, 1'b0);
        sendByte(seq[5], 1'b0, 1'b0);
        bad = 0;
        for (int i = 0; i < 6; i++) if (obsEn[i] !== 1'b1 || obsData[i] !== seq[i]) bad = 1;
        checks++;
        if (bad) begin
            errors++;
            $display("[TB] FAIL single_burst_timing: got en0=%b d0=%h d5=%h required en=1 d0=01 d5=02",
                     obsEn[0], obsData[0], obsData[5]);
        end
        checks++;
        if (obsEn[6] !== 1'b0 || obsData[6] !== 8'h00 || obsBusy[6] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_burst_end: got en=%b data=%h busy=%b required 0 00 0",
                     obsEn[6], obsData[6], obsBusy[6]);
        end
        checks++;
        if (gotBytes.size() < 6 || gotBytes[0] !== 8'h01 || {gotBytes[2], gotBytes[1]} !== 16'h0410 ||
            {gotBytes[4], gotBytes[3]} !== 16'h0080 || gotBytes[5] !== 8'h02) begin
            errors++;
            $display("[TB] FAIL single_decode: got %0d bytes required id=1 x=0410 y=0080 scale=2",
                     gotBytes.size());
        end
        checks++;
        if (gotBytes != expBytes) begin
            errors++;
            $display("[TB] FAIL single_model: got %0d bytes required %0d", gotBytes.size(), expBytes.size());
        end
    endtask

    task automatic test_frame_accounting();
        sendByte(8'h02, 1'b0, 1'b0);
        for (int s = 0; s < 2; s++) begin
            sendByte(8'h01, 1'b0, 1'b0);
            for (int i = 0; i < 6; i++) sendByte(8'($urandom), 1'b0, 1'b0);
        end
        sendByte(8'h02, 1'b0, 1'b0);
        checks++;
        if (obsFd[0] !== 1'b1 || obsFd[1] !== 1'b0 || obsBusy[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL frame_pulse: got fd=%b,%b busy=%b required 1,0 busy 0",
                     obsFd[0], obsFd[1], obsBusy[0]);
        end
        checks++;
        if (frameSprites !== 8'd2 || mFrameSprites !== 8'd2) begin
            errors++;
            $display("[TB] FAIL frame_count_two: got %0d required 2", frameSprites);
        end
        sendByte(8'h02, 1'b0, 1'b0);
        checks++;
        if (frameSprites !== 8'd0) begin
            errors++;
            $display("[TB] FAIL frame_count_zero: got %0d required 0", frameSprites);
        end
        checks++;
        if (gotFrames != mFrames) begin
            errors++;
            $display("[TB] FAIL frame_pulses: got %0d required %0d", gotFrames, mFrames);
        end
    endtask

    task automatic test_truncation();
        gotBytes.delete(); expBytes.delete();
        sendByte(8'h01, 1'b0, 1'b0);
        sendByte(8'hAA, 1'b0, 1'b0);
        sendByte(8'hBB, 1'b0, 1'b0);
        releaseCs();
        checks++;
        if (errTrunc !== 1'b1 || busy !== 1'b0 || gotBytes.size() != 0) begin
            errors++;
            $display("[TB] FAIL truncation: got err=%b busy=%b bytes=%0d required 1 0 0",
                     errTrunc, busy, gotBytes.size());
        end
        sendByte(8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) sendByte(8'($urandom), 1'b0, 1'b0);
        checks++;
        if (gotBytes != expBytes || gotBytes.size() != 6) begin
            errors++;
            $display("[TB] FAIL after_truncation: got %0d bytes required %0d", gotBytes.size(), expBytes.size());
        end
    endtask

    task automatic test_overflow();
        gotBytes.delete(); expBytes.delete();
        sendByte(8'h02, 1'b0, 1'b0);
        sendByte(8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) sendByte(8'($urandom), 1'b0, 1'b0);
        sendByte(8'h5A, 1'b1, 1'b0);
        checks++;
        if (errOvf !== 1'b1 || gotBytes.size() != 0 || obsBusy[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overflow: got err=%b bytes=%0d busy=%b required 1 0 0",
                     errOvf, gotBytes.size(), obsBusy[0]);
        end
        sendByte(8'h02, 1'b0, 1'b0);
        checks++;
        if (frameSprites !== mFrameSprites || frameSprites !== 8'd0) begin
            errors++;
            $display("[TB] FAIL overflow_frame: got %0d required 0", frameSprites);
        end
        pulseErrClear();
        checks++;
        if (errOvf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overflow_clear: got %b required 0", errOvf);
        end
    endtask

    task automatic test_unknown_opcode();
        int framesBefore;
        gotBytes.delete(); expBytes.delete();
        framesBefore = gotFrames;
        sendByte(8'h7F, 1'b0, 1'b0);
        checks++;
        if (errUnk !== 1'b1 || obsBusy[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL unknown_flag: got err=%b busy=%b required 1 1", errUnk, obsBusy[0]);
        end
        sendByte(8'h01, 1'b0, 1'b0);
        sendByte(8'h02, 1'b0, 1'b0);
        checks++;
        if (gotFrames != framesBefore || gotBytes.size() != 0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL unknown_discard: got frames=%0d bytes=%0d busy=%b required %0d 0 1",
                     gotFrames, gotBytes.size(), busy, framesBefore);
        end
        releaseCs();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL unknown_release: got busy=%b required 0", busy);
        end
        // Clear coinciding with a new error: the new error must survive.
        sendByte(8'h01, 1'b0, 1'b0);
        sendByte(8'hAA, 1'b0, 1'b0);
        releaseCs();
        sendByte(8'h55, 1'b0, 1'b1);
        checks++;
        if ({errUnk, errTrunc, errOvf} !== {mUnk, mTrunc, mOvf} || {errUnk, errTrunc} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL clear_vs_set: got %b required 100", {errUnk, errTrunc, errOvf});
        end
        releaseCs();
        pulseErrClear();
    endtask

    task automatic test_saturation();
        gotBytes.delete(); expBytes.delete();
        sendByte(8'h02, 1'b0, 1'b0);
        for (int s = 0; s < 256; s++) begin
            sendByte(8'h01, 1'b0, 1'b0);
            for (int i = 0; i < 6; i++) sendByte(8'($urandom), 1'b0, 1'b0);
        end
        sendByte(8'h02, 1'b0, 1'b0);
        checks++;
        if (frameSprites !== 8'd255) begin
            errors++;
            $display("[TB] FAIL saturation: got %0d required 255", frameSprites);
        end
        checks++;
        if (gotBytes != expBytes) begin
            errors++;
            $display("[TB] FAIL saturation_bytes: got %0d required %0d", gotBytes.size(), expBytes.size());
        end
    endtask

    task automatic test_random();
        int sel;
        int k;
        gotBytes.delete(); expBytes.delete();
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 3) begin
                sendByte(8'h01, 1'b0, 1'b0);
                for (int i = 0; i < 6; i++) sendByte(8'($urandom), ($urandom_range(0, 3) == 0), 1'b0);
            end else if (sel == 4) begin
                sendByte(8'h02, 1'b0, 1'b0);
            end else if (sel == 5) begin
                sendByte(8'h00, 1'b0, ($urandom_range(0, 3) == 0));
            end else if (sel == 6) begin
                sendByte(8'h01, 1'b0, 1'b0);
                k = $urandom_range(0, 5);
                for (int i = 0; i < k; i++) sendByte(8'($urandom), 1'b0, 1'b0);
                releaseCs();
            end else if (sel == 7) begin
                sendByte(8'($urandom_range(3, 255)), 1'b0, 1'b0);
                k = $urandom_range(0, 2);
                for (int i = 0; i < k; i++) sendByte(8'($urandom), 1'b0, 1'b0);
                releaseCs();
            end else if (sel == 8) begin
                releaseCs();
            end else begin
                pulseErrClear();
            end
            checks++;
            if ({errUnk, errTrunc, errOvf} !== {mUnk, mTrunc, mOvf} || frameSprites !== mFrameSprites ||
                busy !== (mCollect || mDiscard)) begin
                errors++;
                $display("[TB] FAIL random_step%0d: got err=%b fs=%0d busy=%b required err=%b fs=%0d busy=%b",
                         n, {errUnk, errTrunc, errOvf}, frameSprites, busy,
                         {mUnk, mTrunc, mOvf}, mFrameSprites, (mCollect || mDiscard));
            end
        end
        checks++;
        if (gotBytes != expBytes) begin
            errors++;
            $display("[TB] FAIL random_bytes: got %0d bytes required %0d", gotBytes.size(), expBytes.size());
        end
        checks++;
        if (gotFrames != mFrames || badIdleData != 0 || badBurstLen != 0) begin
            errors++;
            $display("[TB] FAIL random_stream: got frames=%0d idleData=%0d badLen=%0d required %0d 0 0",
                     gotFrames, badIdleData, badBurstLen, mFrames);
        end
    endtask

    task automatic test_reset_mid_burst();
        sendByte(8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) sendByte(8'($urandom), 1'b0, 1'b0);
        sendByte(8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) sendByte(8'($urandom), 1'b0, 1'b0);
        @(negedge clk);
        rxValid = 1'b1; rxByte = 8'hC6; queueFull = 1'b0;
        @(negedge clk);
        rxValid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        checks++;
        if (enqEn !== 1'b1) begin
            errors++;
            $display("[TB] FAIL burst_before_reset: got en=%b required 1", enqEn);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({enqEn, enqData, frameDone, frameSprites, busy, errUnk, errTrunc, errOvf} !== 22'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_burst: got %h required 0",
                     {enqEn, enqData, frameDone, frameSprites, busy, errUnk, errTrunc, errOvf});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        modelReset();
        gotBytes.delete(); expBytes.delete();
        sendByte(8'h02, 1'b0, 1'b0);
        checks++;
        if (frameSprites !== 8'd0 || frameSprites !== mFrameSprites || gotBytes.size() != 0) begin
            errors++;
            $display("[TB] FAIL frame_after_reset: got %0d bytes=%0d required 0 0", frameSprites, gotBytes.size());
        end
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_single_sprite();
        test_frame_accounting();
        test_truncation();
        test_overflow();
        test_unknown_opcode();
        test_saturation();
        test_random();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
